signal_trace_writer: RTL and testbench
======================================

Name: signal_trace_writer

Overview:
- Write side of the shared signal memory that the VGA trace display reads.
- Accepts two independent 12-bit sample streams: ch0 (ECG) and ch1 (EMG).
- Decimates each stream and writes it into a circular buffer of DEPTH words at a fixed per-channel base address.
- One shared single-port write interface, arbitrated round-robin, one write per cycle.

Parameters:
- ADDR_WIDTH, 12, memory word address width.
- DATA_WIDTH, 32, memory word width.
- SAMPLE_WIDTH, 12, input sample width.
- DEPTH, 320, samples per channel buffer (one per displayed column).
- CH0_BASE, 12'h559, first word of the ch0 buffer.
- CH1_BASE, 12'h6AD, first word of the ch1 buffer.
- DECIM, 1, keep one of every DECIM valid samples per channel (DECIM >= 1).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ch0_valid  in  1  ch0 sample strobe, one cycle per sample.
- ch0_sample  in  SAMPLE_WIDTH  ch0 sample, unsigned.
- ch1_valid  in  1  ch1 sample strobe.
- ch1_sample  in  SAMPLE_WIDTH  ch1 sample, unsigned.
- freeze  in  1  while high, samples are ignored and the buffers hold their contents.
- clear_status  in  1  clears the overrun and wrapped flags.
- mem_addr  out  ADDR_WIDTH  write address, registered.
- mem_wdata  out  DATA_WIDTH  write data, registered.
- mem_wen  out  1  write enable, registered, one-cycle pulse per write.
- ch0_wptr  out  9  next ch0 buffer index, 0..DEPTH-1.
- ch1_wptr  out  9  next ch1 buffer index.
- overrun  out  2  sticky per-channel overrun flag; bit0 = ch0.
- wrapped  out  2  sticky flag, set when a channel buffer has been filled at least once.

Behaviour:
- Reset (synchronous, active-high):
  - mem_wen=0, mem_addr=0, mem_wdata=0.
  - Both wptr=0, overrun=0, wrapped=0.
  - Decimation counters=0, pending regs empty, last_grant=ch1, so ch0 wins the first tie.
  - Reset mid-operation discards pending samples; no write issues in the cycle after reset.
- Accept (per channel):
  - valid && !freeze increments the decimation counter, which runs 0..DECIM-1.
  - The sample is accepted when the counter is 0; the counter wraps at DECIM-1.
  - DECIM=1 accepts every sample.
  - An accepted sample loads the channel's one-entry pending register (data + full bit) on that edge.
  - freeze high: valid is ignored, counters hold; already-pending samples are still written.
- Arbitration (each cycle):
  - Only one pending: grant it.
  - Both pending: grant the channel not in last_grant, then update last_grant.
  - On grant, the next edge registers:
    - mem_wen=1
    - mem_addr=base+wptr
    - mem_wdata = sample zero-extended to DATA_WIDTH (bits [11:0]; upper bits 0)
  - The same edge clears the pending full bit and advances wptr.
  - No grant: mem_wen=0 next cycle; addr/data hold their last values.
- Latency: valid sampled at edge N -> pending at N -> mem_wen high after edge N+1, when uncontended. Worst case is one extra cycle for the losing channel.
- Pointer wrap:
  - wptr=DEPTH-1 on grant -> wptr=0 and wrapped[ch] set.
  - Addresses stay within [base, base+DEPTH-1]; the regions never overlap with the default parameters.
- Simultaneous events:
  - New accepted sample on a channel granted in the same cycle: the old value is written and the new one loads pending. Not an overrun.
  - New accepted sample while pending is full and not granted: pending is overwritten with the new sample and overrun[ch] is set. The old sample is lost and wptr does not skip.
  - clear_status in the same cycle as a set event: the set wins.
- Sustained throughput: both channels at full rate (valid every cycle, DECIM=1) overrun by design. Each channel sustains one sample per 2 cycles.

Decomposition:
- Shared package holds:
  - the buffer base addresses and DEPTH
  - SAMPLE_WIDTH
  - a channel-index typedef (0=ECG, 1=EMG)
  The display controller must use the same constants.
- One sub-module, trace_channel_capture: decimation counter, pending register, wptr, and wrapped/overrun flags. Instantiated twice.
- Arbiter and output registers live in the top module.

Test Plan:
- Reset, then ch0_valid one cycle with sample 12'hABC -> exactly one mem_wen pulse two cycles later: addr 12'h559, wdata 32'h00000ABC; ch0_wptr=1.
- ch0 and ch1 valid in the same cycle (12'h111, 12'h222) -> two consecutive writes:
  - first addr 12'h559, data 32'h111
  - then addr 12'h6AD, data 32'h222
  - no overrun
- 320 ch1 samples spaced 3 cycles apart:
  - last write at addr 12'h7EC
  - wptr wraps to 0, wrapped=2'b10
  - sample 321 written at 12'h6AD
- DECIM=4, 8 consecutive ch0 valids with values 0..7 -> writes of 0 and 4 only; ch0_wptr=2.
- Both channels valid every cycle for 6 cycles:
  - overrun=2'b11 after the first contention
  - clear_status the next cycle with inputs idle -> overrun=0
- freeze high during 10 ch0 valids -> no mem_wen and wptr unchanged. Release -> the next valid is written at the unchanged wptr.

Source files
------------

// File: rtl/signal_trace_writer_pkg.sv
// Constants and types shared by the trace writer and the VGA trace display.
package signal_trace_writer_pkg;

  localparam int unsigned ST_ADDR_WIDTH   = 12;
  localparam int unsigned ST_DATA_WIDTH   = 32;
  localparam int unsigned ST_SAMPLE_WIDTH = 12;
  localparam int unsigned ST_DEPTH        = 320;
  localparam int unsigned ST_PTR_WIDTH    = 9;

  localparam logic [ST_ADDR_WIDTH-1:0] ST_CH0_BASE = 12'h559;
  localparam logic [ST_ADDR_WIDTH-1:0] ST_CH1_BASE = 12'h6AD;

  typedef enum logic {
    CH_ECG = 1'b0,
    CH_EMG = 1'b1
  } ch_idx_t;

endpackage

// File: rtl/signal_trace_writer_capture.sv
// Per-channel capture: decimation, one-entry pending slot, circular write
// pointer and the sticky overrun/wrapped flags.
module trace_channel_capture
  import signal_trace_writer_pkg::*;
#(
  parameter int unsigned DECIM        = 1,
  parameter int unsigned DEPTH        = ST_DEPTH,
  parameter int unsigned SAMPLE_WIDTH = ST_SAMPLE_WIDTH,
  parameter int unsigned PTR_WIDTH    = ST_PTR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_valid,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_freeze,
  input  logic                    i_clear,
  input  logic                    i_grant,
  output logic                    o_pending,
  output logic [SAMPLE_WIDTH-1:0] o_sample,
  output logic [PTR_WIDTH-1:0]    o_wptr,
  output logic                    o_overrun,
  output logic                    o_wrapped
);

  localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0]           r_cnt;
  logic                    r_full;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic [PTR_WIDTH-1:0]    r_wptr;
  logic                    r_overrun;
  logic                    r_wrapped;

  logic w_take;
  logic w_accept;
  logic w_grant;
  logic w_cnt_last;
  logic w_ptr_last;

  assign w_take     = i_valid && !i_freeze;
  assign w_accept   = w_take && (r_cnt == '0);
  assign w_grant    = i_grant && r_full;
  assign w_cnt_last = (r_cnt == CW'(DECIM - 1));
  assign w_ptr_last = (r_wptr == PTR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_sample  <= '0;
      r_wptr    <= '0;
      r_overrun <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (w_take) begin
        r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      end

      // A grant and a new accept on the same edge hand the old value to the
      // writer while the new one refills the slot.
      if (w_accept) begin
        r_sample <= i_sample;
        r_full   <= 1'b1;
      end else if (w_grant) begin
        r_full <= 1'b0;
      end

      if (w_grant) begin
        r_wptr <= w_ptr_last ? '0 : r_wptr + 1'b1;
      end

      if (w_accept && r_full && !w_grant) begin
        r_overrun <= 1'b1;
      end else if (i_clear) begin
        r_overrun <= 1'b0;
      end

      if (w_grant && w_ptr_last) begin
        r_wrapped <= 1'b1;
      end else if (i_clear) begin
        r_wrapped <= 1'b0;
      end
    end
  end

  assign o_pending = r_full;
  assign o_sample  = r_sample;
  assign o_wptr    = r_wptr;
  assign o_overrun = r_overrun;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/signal_trace_writer.sv
// Write side of the shared trace memory: two capture channels feeding one
// registered write port through a round-robin arbiter.
module signal_trace_writer
  import signal_trace_writer_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH   = ST_ADDR_WIDTH,
  parameter int unsigned            DATA_WIDTH   = ST_DATA_WIDTH,
  parameter int unsigned            SAMPLE_WIDTH = ST_SAMPLE_WIDTH,
  parameter int unsigned            DEPTH        = ST_DEPTH,
  parameter logic [ADDR_WIDTH-1:0]  CH0_BASE     = ST_CH0_BASE,
  parameter logic [ADDR_WIDTH-1:0]  CH1_BASE     = ST_CH1_BASE,
  parameter int unsigned            DECIM        = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ch0_valid,
  input  logic [SAMPLE_WIDTH-1:0] ch0_sample,
  input  logic                    ch1_valid,
  input  logic [SAMPLE_WIDTH-1:0] ch1_sample,
  input  logic                    freeze,
  input  logic                    clear_status,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_wen,
  output logic [8:0]              ch0_wptr,
  output logic [8:0]              ch1_wptr,
  output logic [1:0]              overrun,
  output logic [1:0]              wrapped
);

  logic                    w_pend0, w_pend1;
  logic [SAMPLE_WIDTH-1:0] w_samp0, w_samp1;
  logic [8:0]              w_wptr0, w_wptr1;
  logic                    w_grant0, w_grant1;

  ch_idx_t                 r_last;
  logic                    r_wen;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  trace_channel_capture #(
    .DECIM        (DECIM),
    .DEPTH        (DEPTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .PTR_WIDTH    (9)
  ) u_cap_ch0 (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (ch0_valid),
    .i_sample  (ch0_sample),
    .i_freeze  (freeze),
    .i_clear   (clear_status),
    .i_grant   (w_grant0),
    .o_pending (w_pend0),
    .o_sample  (w_samp0),
    .o_wptr    (w_wptr0),
    .o_overrun (overrun[0]),
    .o_wrapped (wrapped[0])
  );

  trace_channel_capture #(
    .DECIM        (DECIM),
    .DEPTH        (DEPTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .PTR_WIDTH    (9)
  ) u_cap_ch1 (
    .clock     (clock),
    .reset     (reset),
    .i_valid   (ch1_valid),
    .i_sample  (ch1_sample),
    .i_freeze  (freeze),
    .i_clear   (clear_status),
    .i_grant   (w_grant1),
    .o_pending (w_pend1),
    .o_sample  (w_samp1),
    .o_wptr    (w_wptr1),
    .o_overrun (overrun[1]),
    .o_wrapped (wrapped[1])
  );

  // On a tie, ch0 wins unless it was the last contention winner.
  assign w_grant0 = w_pend0 && (!w_pend1 || (r_last == CH_EMG));
  assign w_grant1 = w_pend1 && !w_grant0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last  <= CH_EMG;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_pend0 && w_pend1) begin
        r_last <= w_grant0 ? CH_ECG : CH_EMG;
      end
      r_wen <= w_grant0 || w_grant1;
      if (w_grant0) begin
        r_addr  <= CH0_BASE + ADDR_WIDTH'(w_wptr0);
        r_wdata <= DATA_WIDTH'(w_samp0);
      end else if (w_grant1) begin
        r_addr  <= CH1_BASE + ADDR_WIDTH'(w_wptr1);
        r_wdata <= DATA_WIDTH'(w_samp1);
      end
    end
  end

  assign mem_wen   = r_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign ch0_wptr  = w_wptr0;
  assign ch1_wptr  = w_wptr1;

endmodule

// File: tb/tb_signal_trace_writer.sv
// Scoreboard bench for signal_trace_writer: default instance plus a DECIM=4 instance.
module tb_signal_trace_writer;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_v0, a_v1, a_frz, a_clr;
  logic [11:0] a_s0, a_s1;
  logic [11:0] a_addr;
  logic [31:0] a_data;
  logic        a_wen;
  logic [8:0]  a_wp0, a_wp1;
  logic [1:0]  a_ovr, a_wrp;

  logic        b_v0, b_v1, b_frz, b_clr;
  logic [11:0] b_s0, b_s1;
  logic [11:0] b_addr;
  logic [31:0] b_data;
  logic        b_wen;
  logic [8:0]  b_wp0, b_wp1;
  logic [1:0]  b_ovr, b_wrp;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;

  signal_trace_writer u_dut_a (
    .clock(clock), .reset(reset),
    .ch0_valid(a_v0), .ch0_sample(a_s0), .ch1_valid(a_v1), .ch1_sample(a_s1),
    .freeze(a_frz), .clear_status(a_clr),
    .mem_addr(a_addr), .mem_wdata(a_data), .mem_wen(a_wen),
    .ch0_wptr(a_wp0), .ch1_wptr(a_wp1), .overrun(a_ovr), .wrapped(a_wrp)
  );

  signal_trace_writer #(.DECIM(4)) u_dut_b (
    .clock(clock), .reset(reset),
    .ch0_valid(b_v0), .ch0_sample(b_s0), .ch1_valid(b_v1), .ch1_sample(b_s1),
    .freeze(b_frz), .clear_status(b_clr),
    .mem_addr(b_addr), .mem_wdata(b_data), .mem_wen(b_wen),
    .ch0_wptr(b_wp0), .ch1_wptr(b_wp1), .overrun(b_ovr), .wrapped(b_wrp)
  );

  // Monitor: every write pulse must match the head of its instance's queue.
  always @(negedge clock) begin
    exp_t e;
    if (a_wen === 1'b1) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_write unexpected: addr=%h data=%h required=no write", a_addr, a_data);
      end else begin
        e = qa.pop_front();
        if (a_addr !== e.addr || a_data !== e.data) begin
          bad++;
          $display("FAIL a_write: addr=%h data=%h required addr=%h data=%h",
                   a_addr, a_data, e.addr, e.data);
        end
      end
    end
    if (b_wen === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_write unexpected: addr=%h data=%h required=no write", b_addr, b_data);
      end else begin
        e = qb.pop_front();
        if (b_addr !== e.addr || b_data !== e.data) begin
          bad++;
          $display("FAIL b_write: addr=%h data=%h required addr=%h data=%h",
                   b_addr, b_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [11:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [11:0] addr, input logic [31:0] data);
    exp_t e;
    e.addr = addr;
    e.data = data;
    qb.push_back(e);
  endtask

  task automatic idle_inputs();
    a_v0 = 0; a_v1 = 0; a_frz = 0; a_clr = 0; a_s0 = '0; a_s1 = '0;
    b_v0 = 0; b_v1 = 0; b_frz = 0; b_clr = 0; b_s0 = '0; b_s1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
      step(1);
      n++;
    end
    step(2);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL %s drain: pending_a=%0d pending_b=%0d required=0", name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_wen",   32'(a_wen),  32'd0);
    chk("rst_addr",  32'(a_addr), 32'd0);
    chk("rst_wdata", a_data,      32'd0);
    chk("rst_wptr",  32'({a_wp1, a_wp0}), 32'd0);
    chk("rst_flags", 32'({a_wrp, a_ovr}), 32'd0);

    // Single ch0 sample
    a_v0 = 1; a_s0 = 12'hABC;
    push_a(12'h559, 32'h00000ABC);
    step(1);
    a_v0 = 0;
    drain("single");
    chk("single_wptr0", 32'(a_wp0), 32'd1);

    // Simultaneous ch0/ch1: ch0 wins the first tie
    do_reset();
    a_v0 = 1; a_s0 = 12'h111; a_v1 = 1; a_s1 = 12'h222;
    push_a(12'h559, 32'h111);
    push_a(12'h6AD, 32'h222);
    step(1);
    idle_inputs();
    drain("tie");
    chk("tie_overrun", 32'(a_ovr), 32'd0);

    // 320 ch1 samples fill the buffer, 321st wraps to the base
    do_reset();
    for (int unsigned i = 0; i < 320; i++) begin
      a_v1 = 1; a_s1 = 12'(i);
      push_a(12'h6AD + 12'(i), 32'(i));
      step(1);
      a_v1 = 0;
      step(2);
    end
    drain("fill");
    chk("fill_wptr1",   32'(a_wp1), 32'd0);
    chk("fill_wrapped", 32'(a_wrp), 32'd2);
    a_v1 = 1; a_s1 = 12'hFED;
    push_a(12'h6AD, 32'h00000FED);
    step(1);
    a_v1 = 0;
    drain("wrap");
    chk("wrap_wptr1", 32'(a_wp1), 32'd1);

    // DECIM=4 instance keeps samples 0 and 4 of 0..7
    do_reset();
    push_b(12'h559, 32'd0);
    push_b(12'h55A, 32'd4);
    for (int unsigned i = 0; i < 8; i++) begin
      b_v0 = 1; b_s0 = 12'(i);
      step(1);
    end
    b_v0 = 0;
    drain("decim");
    chk("decim_wptr0", 32'(b_wp0), 32'd2);

    // Both channels every cycle: alternating grants, losers overwritten
    do_reset();
    push_a(12'h559, 32'h100);
    push_a(12'h6AD, 32'h201);
    push_a(12'h55A, 32'h102);
    push_a(12'h6AE, 32'h203);
    push_a(12'h55B, 32'h104);
    push_a(12'h6AF, 32'h205);
    push_a(12'h55C, 32'h105);
    for (int unsigned i = 0; i < 6; i++) begin
      a_v0 = 1; a_s0 = 12'h100 + 12'(i);
      a_v1 = 1; a_s1 = 12'h200 + 12'(i);
      step(1);
    end
    a_v0 = 0; a_v1 = 0;
    chk("contend_overrun", 32'(a_ovr), 32'd3);
    a_clr = 1;
    step(1);
    a_clr = 0;
    chk("clear_overrun", 32'(a_ovr), 32'd0);
    drain("contend");
    chk("contend_wptr", 32'({a_wp1, a_wp0}), 32'({9'd3, 9'd4}));

    // Freeze ignores samples and holds the pointer
    do_reset();
    a_v0 = 1; a_s0 = 12'h5A5;
    push_a(12'h559, 32'h5A5);
    step(1);
    a_v0 = 0;
    step(3);
    a_frz = 1;
    for (int unsigned i = 0; i < 10; i++) begin
      a_v0 = 1; a_s0 = 12'h700 + 12'(i);
      step(1);
    end
    a_v0 = 0; a_frz = 0;
    step(3);
    chk("freeze_wptr0", 32'(a_wp0), 32'd1);
    a_v0 = 1; a_s0 = 12'h3C3;
    push_a(12'h55A, 32'h3C3);
    step(1);
    a_v0 = 0;
    drain("unfreeze");
    chk("unfreeze_wptr0", 32'(a_wp0), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
